pos_table_engine: RTL and testbench

//  Programmable N-input boolean function unit in product-of-sums form.
//  - Function is held as a maxterm mask: bit i = 1 means f = 0 at input code i.
//  - Evaluates input words through a registered valid/ready stage.
//  - Mask bits are rewritable at run time.
//  - A sweep FSM walks every input code and reports the maxterm count.
//  - Sits beside the lab's fixed gate-level SOP/POS functions as the generic, clocked replacement.

---
 rtl/pos_table_engine.sv | 107 ++++++++++
 tb/tb_pos_table_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pos_table_engine.sv
// rtl/pos_table_engine.sv - programmable product-of-sums function unit
// Maxterm mask with a one-stage valid/ready evaluator and a maxterm-count sweep FSM.
module pos_table_engine #(
  parameter int N_IN = 4,
  parameter logic [(1<<N_IN)-1:0] MAXTERM_INIT = 16'h551F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            f_out,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_val,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   zero_count
);

  localparam int SIZE = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t          state, state_next;
  logic [SIZE-1:0] mask;
  logic [N_IN-1:0] idx;
  logic [N_IN:0]   acc;
  logic [N_IN:0]   acc_next;
  logic            accept;
  logic            idx_last;

  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);
  assign in_ready   = !sweep_busy && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign idx_last   = &idx;
  assign acc_next   = acc + {{N_IN{1'b0}}, mask[idx]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sweep_start) state_next = SWEEP;
      SWEEP:   if (idx_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // zero_count is loaded on the exit edge so it is already valid while DONE is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      acc        <= '0;
      zero_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sweep_start) begin
            idx <= '0;
            acc <= '0;
          end
        end
        SWEEP: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx_last) zero_count <= acc_next;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= MAXTERM_INIT;
    end else if (cfg_we && !sweep_busy) begin
      mask[cfg_addr] <= cfg_val;
    end
  end

  // Evaluation reads the mask as it stood before any same-edge cfg write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      f_out     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      f_out     <= ~mask[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pos_table_engine.sv
// tb/tb_pos_table_engine.sv - scoreboard bench for pos_table_engine
// Stimulus pushes expected f_out values; a negedge monitor pops them on each take.
module tb_pos_table_engine;

  localparam logic [15:0] INIT = 16'h551F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       f_out;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic       cfg_val = 1'b0;
  logic       sweep_start = 1'b0;
  logic       sweep_busy;
  logic       sweep_done;
  logic [4:0] zero_count;

  int total = 0;
  int bad = 0;
  logic [15:0] model = INIT;
  logic exp_q[$];

  pos_table_engine #(.N_IN(4), .MAXTERM_INIT(INIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .f_out(f_out),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_val(cfg_val),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .zero_count(zero_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        chk("f_out", f_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] code, input bit keep, output int waited);
    in_valid = 1'b1;
    in_data  = code;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk("accept_timeout", in_ready, 1);
    exp_q.push_back(~model[code]);
    tick();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic write_bit(input logic [3:0] addr, input logic val);
    cfg_we = 1'b1; cfg_addr = addr; cfg_val = val;
    tick();
    model[addr] = val;
    cfg_we = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    @(negedge clk);
    while (out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("drain_timeout", out_valid, 0);
    tick();
  endtask

  task automatic do_sweep(input int exp_cnt, input bit with_word, input logic [3:0] code,
                          input bit bad_write);
    int busy = 0;
    bit seen = 0;
    sweep_start = 1'b1;
    if (with_word) begin
      in_valid = 1'b1; in_data = code;
      @(negedge clk);
      chk("sweep_start_accept", in_ready, 1);
      exp_q.push_back(~model[code]);
    end
    tick();
    sweep_start = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (sweep_done) begin
        seen = 1;
        chk("zero_count", zero_count, exp_cnt);
        chk("busy_in_done", sweep_busy, 0);
      end else if (sweep_busy) begin
        busy++;
        chk("in_ready_in_sweep", in_ready, 0);
        if (bad_write && busy == 3) begin
          cfg_we = 1'b1; cfg_addr = 4'd0; cfg_val = 1'b0;
        end
      end
    end
    chk("sweep_done_seen", seen, 1);
    chk("busy_cycles", busy, 16);
    tick();
    @(negedge clk);
    chk("done_one_cycle", sweep_done, 0);
    chk("zero_count_hold", zero_count, exp_cnt);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int busy;
    int done_seen;
    logic [3:0] burst [4];
    burst[0] = 4'd0; burst[1] = 4'd5; burst[2] = 4'd10; burst[3] = 4'd15;

    // T1 reset state and basic evaluation
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_f_out", f_out, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_zero_count", zero_count, 0);
    tick();
    rst = 1'b0;
    tick();
    send(4'b0101, 0, w);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("t1_code5", f_out, 1);
    tick();
    send(4'b1100, 0, w);
    drain();

    // T2 backpressure then back-to-back
    out_ready = 1'b0;
    send(4'd7, 0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_f_out", f_out, 1);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(burst[i], i != 3, w);
      chk("b2b_wait", w, 0);
    end
    drain();

    // T3 same-cycle cfg write and accept
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_val = 1'b1;
    send(4'd5, 0, w);
    model[5] = 1'b1;
    cfg_we = 1'b0;
    send(4'd5, 0, w);
    drain();

    // T4 sweep of default-plus-bit5 mask would be 10; restore bit 5 first
    write_bit(4'd5, 1'b0);
    do_sweep(9, 1, 4'd3, 1);
    drain();
    send(4'd0, 0, w);
    drain();

    // T5 all zero then all one
    for (int i = 0; i < 16; i++) write_bit(4'(i), 1'b0);
    do_sweep(0, 0, 4'd0, 0);
    for (int i = 0; i < 16; i++) write_bit(4'(i), 1'b1);
    do_sweep(16, 0, 4'd0, 0);

    // T6 reset in the middle of a sweep
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    busy = 0;
    while (busy < 7) begin
      @(negedge clk);
      if (sweep_busy) busy++;
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", sweep_busy, 0);
    chk("mid_rst_zero_count", zero_count, 0);
    model = INIT;
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sweep_done) done_seen++;
    end
    chk("no_done_after_rst", done_seen, 0);
    tick();
    send(4'd5, 0, w);
    send(4'd12, 0, w);
    drain();
    do_sweep(9, 0, 4'd0, 0);

    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
